lcv_alu_rr_arbiter: RTL and testbench

Shares one registered single-cycle-latency ALU (one-hot 8-bit op, registered output) between two requesters. Uses round-robin arbitration and valid/ready handshakes. Results are returned through a 2-entry response FIFO, tagged with the requester ID. Sits between the issue stages of two pipelines and the shared ALU instance.

---
 rtl/lcv_alu_rr_arbiter_if.sv | 53 +++++
 rtl/lcv_alu_rr_arbiter.sv | 103 ++++++++++
 tb/tb_lcv_alu_rr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcv_alu_rr_arbiter_if.sv
// Purpose: bundles the two requester handshakes, the shared-ALU drive/return
//          and the tagged response channel of lcv_alu_rr_arbiter.
// Ports:   master = requester/ALU/consumer side, slave = arbiter side.
interface lcv_alu_rr_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 8
);
  // requester 0
  logic                req0_valid;
  logic                req0_ready;
  logic [OP_WIDTH-1:0] req0_op;
  logic [WIDTH-1:0]    req0_a;
  logic [WIDTH-1:0]    req0_b;
  // requester 1
  logic                req1_valid;
  logic                req1_ready;
  logic [OP_WIDTH-1:0] req1_op;
  logic [WIDTH-1:0]    req1_a;
  logic [WIDTH-1:0]    req1_b;
  // shared ALU
  logic [WIDTH-1:0]    alu_inp_a;
  logic [WIDTH-1:0]    alu_inp_b;
  logic [OP_WIDTH-1:0] alu_inp_op;
  logic [WIDTH-1:0]    alu_outp_data;
  // response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_id;
  logic                busy;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_inp_a, alu_inp_b, alu_inp_op,
    output alu_outp_data,
    input  rsp_valid, rsp_data, rsp_id, busy,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_inp_a, alu_inp_b, alu_inp_op,
    input  alu_outp_data,
    output rsp_valid, rsp_data, rsp_id, busy,
    input  rsp_ready
  );
endinterface

// File: rtl/lcv_alu_rr_arbiter.sv
// Purpose: round-robin share of one registered ALU between two requesters;
//          results return through a 2-entry FIFO tagged with requester id.
// Latency: issue-to-response 2 cycles; 1 op/cycle sustained with rsp_ready=1.
// Backpressure: reqN_ready drops when FIFO occupancy plus the inflight op,
//          less a same-cycle pop, would reach 2.
// Ports:   clk, rst (async active-high), bus (slave modport of the _if).
module lcv_alu_rr_arbiter #(
  parameter int WIDTH    = 32,
  parameter int OP_WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  lcv_alu_rr_arbiter_if.slave bus
);

  logic             r_inflight;
  logic             r_inflight_id;
  logic             r_last_grant;
  logic [1:0]       r_count;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [WIDTH-1:0] r_fifo_dat [2];
  logic             r_fifo_id  [2];

  logic       w_pop;
  logic [2:0] w_occupancy;
  logic       w_can_issue;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_issue;

  assign w_pop = bus.rsp_valid & bus.rsp_ready;

  // Slots that will still be committed after this cycle's pop. A pop frees a
  // slot combinationally, so rsp_ready feeds reqN_ready in the same cycle;
  // this is what sustains one op per cycle.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_can_issue = (w_occupancy < 3'd2);

  // Tie goes to the requester that did not win the last issue.
  assign w_grant0 = w_can_issue & bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_grant1 = w_can_issue & bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_issue  = w_grant0 | w_grant1;

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // Idle cycles present op=0 so the ALU produces 0 rather than garbage.
  always_comb begin
    bus.alu_inp_a  = '0;
    bus.alu_inp_b  = '0;
    bus.alu_inp_op = {OP_WIDTH{1'b0}};
    if (w_grant0) begin
      bus.alu_inp_a  = bus.req0_a;
      bus.alu_inp_b  = bus.req0_b;
      bus.alu_inp_op = bus.req0_op;
    end else if (w_grant1) begin
      bus.alu_inp_a  = bus.req1_a;
      bus.alu_inp_b  = bus.req1_b;
      bus.alu_inp_op = bus.req1_op;
    end
  end

  assign bus.rsp_valid = (r_count != 2'd0);
  assign bus.rsp_data  = r_fifo_dat[r_rd_ptr];
  assign bus.rsp_id    = r_fifo_id[r_rd_ptr];
  assign bus.busy      = r_inflight | (r_count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight    <= 1'b0;
      r_inflight_id <= 1'b0;
      r_last_grant  <= 1'b1;
      r_count       <= 2'd0;
      r_rd_ptr      <= 1'b0;
      r_wr_ptr      <= 1'b0;
      r_fifo_dat[0] <= '0;
      r_fifo_dat[1] <= '0;
      r_fifo_id[0]  <= 1'b0;
      r_fifo_id[1]  <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_id <= w_grant1;
        r_last_grant  <= w_grant1;
      end
      // The ALU result for last cycle's issue is valid now; capture it.
      if (r_inflight) begin
        r_fifo_dat[r_wr_ptr] <= bus.alu_outp_data;
        r_fifo_id[r_wr_ptr]  <= r_inflight_id;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(r_inflight && (r_count == 2'd2) && !w_pop));

endmodule

// File: tb/tb_lcv_alu_rr_arbiter.sv
// Purpose: self-checking bench for lcv_alu_rr_arbiter with a registered ALU
//          stand-in, directed scenarios and randomized traffic vs a queue model.
// Ports:   none (top-level bench).
module tb_lcv_alu_rr_arbiter;
  localparam int WIDTH    = 32;
  localparam int OP_WIDTH = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcv_alu_rr_arbiter_if #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

  lcv_alu_rr_arbiter #(.WIDTH(WIDTH), .OP_WIDTH(OP_WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Registered ALU stand-in, written as a sum of masked terms.
  function automatic logic [31:0] alu_hw(logic [7:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = ({32{op[0]}} & (a + b)) | ({32{op[1]}} & (a - b)) |
        {31'b0, op[2] & (a < b)} | {31'b0, op[3] & ($signed(a) < $signed(b))} |
        ({32{op[4]}} & (a & b)) | ({32{op[5]}} & (a | b)) | ({32{op[6]}} & (a ^ b));
    return r;
  endfunction

  always @(posedge clk) bus.alu_outp_data <= alu_hw(bus.alu_inp_op, bus.alu_inp_a, bus.alu_inp_b);

  // Reference result straight from the op table.
  function automatic logic [31:0] ref_result(logic [7:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      8'h01:   return a + b;
      8'h02:   return a - b;
      8'h04:   return (a < b) ? 32'd1 : 32'd0;
      8'h08:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      8'h10:   return a & b;
      8'h20:   return a | b;
      8'h40:   return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  typedef struct {
    logic        id;
    logic [31:0] dat;
    int          vis;  // first cycle the response may be seen
  } rsp_t;

  rsp_t mq[$];
  logic m_last;
  int   cyc;
  int   total = 0;
  int   bad   = 0;

  // values sampled by the last step()
  logic        s_rdy0, s_rdy1, s_vld, s_id, s_busy, s_iss0, s_iss1;
  logic [31:0] s_dat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = '0; bus.req1_a = '0; bus.req1_b = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    bus.rsp_ready = 1'b1;
    mq.delete();
    m_last = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock cycle: check at negedge against the model, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic step();
    logic e_vld, e_pop, e_can;
    int   win;  // -1 none, else requester id
    @(negedge clk);
    e_vld = (mq.size() > 0) && (mq[0].vis <= cyc);
    e_pop = e_vld && bus.rsp_ready;
    e_can = (mq.size() - (e_pop ? 1 : 0)) < 2;
    win = -1;
    if (e_can) begin
      if (bus.req0_valid && bus.req1_valid) win = m_last ? 0 : 1;
      else if (bus.req0_valid)              win = 0;
      else if (bus.req1_valid)              win = 1;
    end
    s_rdy0 = bus.req0_ready; s_rdy1 = bus.req1_ready;
    s_vld  = bus.rsp_valid;  s_dat  = bus.rsp_data;
    s_id   = bus.rsp_id;     s_busy = bus.busy;
    s_iss0 = bus.req0_valid && bus.req0_ready;
    s_iss1 = bus.req1_valid && bus.req1_ready;
    check("req0_ready", s_rdy0, (win == 0) ? 1 : 0);
    check("req1_ready", s_rdy1, (win == 1) ? 1 : 0);
    check("rsp_valid", s_vld, e_vld);
    check("busy", s_busy, (mq.size() != 0) ? 1 : 0);
    if (e_vld) begin
      check("rsp_data", s_dat, mq[0].dat);
      check("rsp_id", s_id, mq[0].id);
    end
    if (win == 0)      check("alu_op", bus.alu_inp_op, bus.req0_op);
    else if (win == 1) check("alu_op", bus.alu_inp_op, bus.req1_op);
    else               check("alu_op_idle", bus.alu_inp_op, 0);
    if (e_pop) void'(mq.pop_front());
    if (win == 0) mq.push_back('{1'b0, ref_result(bus.req0_op, bus.req0_a, bus.req0_b), cyc + 2});
    if (win == 1) mq.push_back('{1'b1, ref_result(bus.req1_op, bus.req1_a, bus.req1_b), cyc + 2});
    if (win >= 0) m_last = (win == 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [7:0] rand_op();
    logic [7:0] ops [8];
    ops = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    return ops[$urandom_range(0, 7)];
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'(int'($urandom_range(0, 15)));
      default: return $urandom;
    endcase
  endfunction

  int n_iss;

  initial begin
    cyc = 0;
    rst = 1'b1;
    do_reset();

    // reset state
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_busy", bus.busy, 0);

    // single ADD 5+7
    bus.req0_valid = 1'b1; bus.req0_op = 8'h01; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
    step();
    check("add_rdy_c0", s_rdy0, 1);
    idle_inputs();
    step();
    check("add_busy_c1", s_busy, 1);
    check("add_vld_c1", s_vld, 0);
    step();
    check("add_vld_c2", s_vld, 1);
    check("add_dat_c2", s_dat, 32'd12);
    check("add_id_c2", s_id, 0);
    check("add_busy_c2", s_busy, 1);
    step();
    check("add_busy_c3", s_busy, 0);

    // both valid every cycle: alternating grants, one response per cycle
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_op = 8'h02; bus.req0_a = 32'd10;   bus.req0_b = 32'd3;
    bus.req1_valid = 1'b1; bus.req1_op = 8'h40; bus.req1_a = 32'hF0;   bus.req1_b = 32'hFF;
    for (int i = 0; i < 8; i++) begin
      step();
      check("alt_grant", s_iss1, i % 2);
      if (i >= 2) begin
        check("alt_vld", s_vld, 1);
        check("alt_dat", s_dat, (i % 2 == 0) ? 32'd7 : 32'h0F);
        check("alt_id", s_id, i % 2);
      end
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) step();

    // backpressure: exactly two accepted, then release
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 8'h01; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    n_iss = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_iss0) n_iss++;
    end
    check("bp_issues", n_iss, 2);
    check("bp_rdy_low", s_rdy0, 0);
    bus.rsp_ready = 1'b1;
    step();
    check("bp_rel_vld", s_vld, 1);
    check("bp_rel_rdy", s_rdy0, 1);
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // signed vs unsigned compare
    bus.req0_valid = 1'b1; bus.req0_op = 8'h08; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1;
    step();
    idle_inputs();
    step();
    step();
    check("slts", s_dat, 32'd1);
    bus.req0_valid = 1'b1; bus.req0_op = 8'h04; bus.req0_a = 32'hFFFF_FFFF; bus.req0_b = 32'd1;
    step();
    idle_inputs();
    step();
    step();
    check("sltu", s_dat, 32'd0);
    check("sltu_vld", s_vld, 1);

    // reset mid-operation with one FIFO entry and one op inflight
    do_reset();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 8'h01; bus.req0_a = 32'd3; bus.req0_b = 32'd4;
    step();
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    check("mid_rst_vld", bus.rsp_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    mq.delete();
    m_last = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    bus.req0_valid = 1'b1; bus.req0_op = 8'h10; bus.req0_a = 32'hFF; bus.req0_b = 32'h0F;
    bus.req1_valid = 1'b1; bus.req1_op = 8'h20; bus.req1_a = 32'h10; bus.req1_b = 32'h01;
    step();
    check("post_rst_r0", s_rdy0, 1);
    check("post_rst_r1", s_rdy1, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) step();

    // req1 alone, then tie goes to req0
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_op = 8'h01; bus.req1_a = 32'd2; bus.req1_b = 32'd2;
    step();
    check("r1_alone", s_rdy1, 1);
    bus.req0_valid = 1'b1; bus.req0_op = 8'h02; bus.req0_a = 32'd9; bus.req0_b = 32'd4;
    step();
    check("tie_r0", s_rdy0, 1);
    check("tie_r1", s_rdy1, 0);
    idle_inputs();
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (bus.req0_valid && !s_iss0) begin
        if ($urandom_range(0, 7) == 0) bus.req0_valid = 1'b0;
      end else begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_op = rand_op(); bus.req0_a = rand_opnd(); bus.req0_b = rand_opnd();
      end
      if (bus.req1_valid && !s_iss1) begin
        if ($urandom_range(0, 7) == 0) bus.req1_valid = 1'b0;
      end else begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_op = rand_op(); bus.req1_a = rand_opnd(); bus.req1_b = rand_opnd();
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    idle_inputs();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("drain_busy", s_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
